// File: rtl/bus2_master.sv
// Cache-side master for bus 2. Takes one line read or line write from the cache, drives the
// shared C2/A2/D2 bus, waits for the memory controller's response burst, then reports back.
module bus2_master #(
    parameter int ADDR2_BUS_SIZE  = 14,
    parameter int DATA2_BUS_SIZE  = 16,
    parameter int CTR2_BUS_SIZE   = 2,
    parameter int LINE_SIZE_BYTES = 16,
    parameter int TIMEOUT         = 256
) (
    input  logic                           CLK,
    input  logic                           RESET,
    inout  tri logic [ADDR2_BUS_SIZE-1:0]  A2_WIRE,
    inout  tri logic [DATA2_BUS_SIZE-1:0]  D2_WIRE,
    inout  tri logic [CTR2_BUS_SIZE-1:0]   C2_WIRE,
    input  logic                           REQ_VALID,
    output logic                           REQ_READY,
    input  logic                           REQ_WRITE,
    input  logic [ADDR2_BUS_SIZE-1:0]      REQ_ADDR,
    input  logic [8*LINE_SIZE_BYTES-1:0]   REQ_WDATA,
    output logic                           RESP_VALID,
    output logic [8*LINE_SIZE_BYTES-1:0]   RESP_RDATA,
    output logic                           RESP_ERR
);

    localparam int LINE_BITS = 8 * LINE_SIZE_BYTES;
    localparam int BEATS     = LINE_BITS / DATA2_BUS_SIZE;
    localparam int CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TMO_W     = $clog2(TIMEOUT + 1);

    localparam logic [CTR2_BUS_SIZE-1:0] C2_RESPONSE   = CTR2_BUS_SIZE'(1);
    localparam logic [CTR2_BUS_SIZE-1:0] C2_READ_LINE  = CTR2_BUS_SIZE'(2);
    localparam logic [CTR2_BUS_SIZE-1:0] C2_WRITE_LINE = CTR2_BUS_SIZE'(3);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_RECV,
        ST_DONE
    } state_t;

    state_t                    state_q,      state_d;
    logic [CNT_W-1:0]          cnt_q,        cnt_d;
    logic [TMO_W-1:0]          tmo_q,        tmo_d;
    logic                      write_q,      write_d;
    logic [ADDR2_BUS_SIZE-1:0] addr_q,       addr_d;
    logic [LINE_BITS-1:0]      wdata_q,      wdata_d;
    logic [LINE_BITS-1:0]      line_q,       line_d;
    logic [LINE_BITS-1:0]      rdata_q,      rdata_d;
    logic                      req_ready_q,  req_ready_d;
    logic                      resp_valid_q, resp_valid_d;
    logic                      resp_err_q,   resp_err_d;

    logic go_done;
    logic done_err;
    logic send_drv;
    logic rsp_seen;

    // Gating with RESET lets the bus float the instant reset asserts, independent of the flops.
    assign send_drv = RESET && (state_q == ST_SEND);
    assign rsp_seen = (C2_WIRE == C2_RESPONSE);

    assign C2_WIRE = send_drv ? (write_q ? C2_WRITE_LINE : C2_READ_LINE)
                              : {CTR2_BUS_SIZE{1'bz}};
    assign A2_WIRE = send_drv ? addr_q : {ADDR2_BUS_SIZE{1'bz}};
    assign D2_WIRE = (send_drv && write_q) ? wdata_q[cnt_q*DATA2_BUS_SIZE +: DATA2_BUS_SIZE]
                                           : {DATA2_BUS_SIZE{1'bz}};

    always_comb begin
        // NOTE: every variable gets its default before the case, so no path leaves one
        // unassigned and no latch is inferred.
        state_d  = state_q;
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        line_d   = line_q;
        go_done  = 1'b0;
        done_err = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (REQ_VALID && req_ready_q) begin
                    write_d = REQ_WRITE;
                    addr_d  = REQ_ADDR;
                    wdata_d = REQ_WDATA;
                    cnt_d   = '0;
                    tmo_d   = '0;
                    line_d  = '0;
                    state_d = ST_SEND;
                end
            end

            ST_SEND: begin
                if (!write_q || (cnt_q == CNT_LAST)) begin
                    cnt_d   = '0;
                    tmo_d   = '0;
                    state_d = ST_WAIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_WAIT: begin
                if (rsp_seen) begin
                    if (write_q) begin
                        go_done = 1'b1;
                    end else begin
                        line_d[0 +: DATA2_BUS_SIZE] = D2_WIRE;
                        cnt_d   = CNT_W'(1);
                        state_d = ST_RECV;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    go_done  = 1'b1;
                    done_err = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            ST_RECV: begin
                if (rsp_seen) begin
                    line_d[cnt_q*DATA2_BUS_SIZE +: DATA2_BUS_SIZE] = D2_WIRE;
                    if (cnt_q == CNT_LAST) begin
                        go_done = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    // Broken burst: beats captured so far stay, the rest were cleared at accept.
                    go_done  = 1'b1;
                    done_err = 1'b1;
                end
            end

            ST_DONE: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase

        if (go_done) begin
            state_d = ST_DONE;
        end

        resp_valid_d = go_done;
        resp_err_d   = go_done && done_err;
        rdata_d      = (go_done && !write_q) ? line_d : rdata_q;
        req_ready_d  = (state_d == ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples
        // the values from before the edge regardless of statement order.
        if (!RESET) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            tmo_q        <= '0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            // NOTE: the line registers are plain flops, not a RAM, so they take the async
            // reset too; RESP_RDATA must read zero out of reset.
            line_q       <= '0;
            rdata_q      <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tmo_q        <= tmo_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            line_q       <= line_d;
            rdata_q      <= rdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign REQ_READY  = req_ready_q;
    assign RESP_VALID = resp_valid_q;
    assign RESP_ERR   = resp_err_q;
    assign RESP_RDATA = rdata_q;

endmodule

// File: tb/tb_bus2_master.sv
// Bench for bus2_master: a per-cycle timeline model built from the transaction timing rules,
// a memory-side slave on pulled-down bus nets, and one compare process sampling each cycle.
module tb_bus2_master;

    localparam int BEATS   = 8;
    localparam int TIMEOUT = 256;
    localparam int MAXC    = 1024;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic [13:0]  req_addr;
    logic [127:0] req_wdata;
    logic         resp_valid;
    logic [127:0] resp_rdata;
    logic         resp_err;

    // Undriven bus bits read as 0, so a released bus is expected to read 0.
    tri0 [1:0]  c2_w;
    tri0 [13:0] a2_w;
    tri0 [15:0] d2_w;

    logic        slv_en;
    logic [1:0]  slv_c2;
    logic [15:0] slv_d2;

    assign c2_w = slv_en ? slv_c2 : 2'bz;
    assign d2_w = slv_en ? slv_d2 : 16'bz;

    bus2_master dut (
        .CLK        (clk),
        .RESET      (rst_n),
        .A2_WIRE    (a2_w),
        .D2_WIRE    (d2_w),
        .C2_WIRE    (c2_w),
        .REQ_VALID  (req_valid),
        .REQ_READY  (req_ready),
        .REQ_WRITE  (req_write),
        .REQ_ADDR   (req_addr),
        .REQ_WDATA  (req_wdata),
        .RESP_VALID (resp_valid),
        .RESP_RDATA (resp_rdata),
        .RESP_ERR   (resp_err)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bit           exp_drv   [MAXC];
    bit           exp_dd    [MAXC];
    logic [1:0]   exp_c2    [MAXC];
    logic [13:0]  exp_a2    [MAXC];
    logic [15:0]  exp_d2    [MAXC];
    bit           exp_rdy   [MAXC];
    bit           exp_vld   [MAXC];
    bit           exp_err   [MAXC];
    bit           exp_rdchk [MAXC];
    logic [127:0] exp_line  [MAXC];

    int vld_cyc  = -1;
    int vld_cnt  = 0;
    bit last_err = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic void set_ready(input int from, input bit v);
        for (int i = from; i < MAXC; i++) exp_rdy[i] = v;
    endfunction

    function automatic logic [15:0] rbeat(input int k);
        return 16'hA000 + 16'(k);
    endfunction

    // Compare process: outputs are stable mid-cycle, and the slave has settled 1 time unit after negedge.
    initial begin
        logic [1:0]  ec2;
        logic [13:0] ea2;
        logic [15:0] ed2;
        forever begin
            @(negedge clk);
            #1;
            if (cyc < MAXC) begin
                if (exp_drv[cyc]) begin
                    ec2 = exp_c2[cyc];
                    ea2 = exp_a2[cyc];
                    ed2 = exp_dd[cyc] ? exp_d2[cyc] : (slv_en ? slv_d2 : 16'h0);
                end else if (slv_en) begin
                    ec2 = slv_c2;
                    ea2 = 14'h0;
                    ed2 = slv_d2;
                end else begin
                    ec2 = 2'h0;
                    ea2 = 14'h0;
                    ed2 = 16'h0;
                end
                check("bus_c2", c2_w, ec2);
                check("bus_a2", a2_w, ea2);
                check("bus_d2", d2_w, ed2);
                check("req_ready", req_ready, exp_rdy[cyc]);
                check("resp_valid", resp_valid, exp_vld[cyc]);
                if (exp_vld[cyc]) check("resp_err", resp_err, exp_err[cyc]);
                if (exp_rdchk[cyc]) check("resp_rdata", resp_rdata, exp_line[cyc]);
                if (resp_valid === 1'b1) begin
                    vld_cyc  = cyc;
                    vld_cnt++;
                    last_err = resp_err;
                end
            end
        end
    end

    // One request plus the slave's reply. delay<0: slave stays silent. nbeats<BEATS on a read
    // means the burst is cut by a C2=NOP cycle. Returns the acceptance cycle and the DONE cycle.
    task automatic run_txn(input bit wr, input logic [13:0] addr, input logic [127:0] wdata,
                           input int delay, input int nbeats, output int t_acc, output int done);
        int           rel;
        int           r;
        bit           err;
        logic [127:0] line;
        tick();
        t_acc     = cyc + 1;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;

        rel = wr ? t_acc + BEATS : t_acc + 1;
        r   = rel + delay;
        if (delay < 0) begin
            done = rel + TIMEOUT;
            err  = 1'b1;
        end else if (wr) begin
            done = r + 1;
            err  = 1'b0;
        end else if (nbeats >= BEATS) begin
            done = r + BEATS;
            err  = 1'b0;
        end else begin
            done = r + nbeats + 1;
            err  = 1'b1;
        end

        if (wr) begin
            for (int k = 0; k < BEATS; k++) begin
                exp_drv[t_acc+k] = 1'b1;
                exp_c2[t_acc+k]  = 2'd3;
                exp_a2[t_acc+k]  = addr;
                exp_dd[t_acc+k]  = 1'b1;
                exp_d2[t_acc+k]  = wdata[k*16 +: 16];
            end
        end else begin
            exp_drv[t_acc] = 1'b1;
            exp_c2[t_acc]  = 2'd2;
            exp_a2[t_acc]  = addr;
            exp_dd[t_acc]  = 1'b0;
        end
        set_ready(t_acc, 1'b0);
        set_ready(done + 1, 1'b1);
        exp_vld[done] = 1'b1;
        exp_err[done] = err;
        if (!wr && delay >= 0) begin
            line = '0;
            for (int k = 0; k < nbeats && k < BEATS; k++) line[k*16 +: 16] = rbeat(k);
            exp_rdchk[done] = 1'b1;
            exp_line[done]  = line;
        end

        for (int cy = t_acc; cy <= done + 1; cy++) begin
            tick();
            req_valid = 1'b0;
            slv_en    = 1'b0;
            slv_c2    = 2'd0;
            slv_d2    = 16'h0;
            if (delay >= 0) begin
                if (wr && cy == r) begin
                    slv_en = 1'b1;
                    slv_c2 = 2'd1;
                end else if (!wr && cy >= r && cy < r + nbeats) begin
                    slv_en = 1'b1;
                    slv_c2 = 2'd1;
                    slv_d2 = rbeat(cy - r);
                end else if (!wr && nbeats < BEATS && cy == r + nbeats) begin
                    slv_en = 1'b1;
                    slv_c2 = 2'd0;
                end
            end
        end
    endtask

    initial begin
        int t;
        int d;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        slv_en    = 1'b0;
        slv_c2    = 2'd0;
        slv_d2    = 16'h0;

        // Reset held for three cycles, then released.
        repeat (2) tick();
        check("rst_ready_low", req_ready, 1'b0);
        check("rst_bus_c2", c2_w, 2'd0);
        tick();
        rst_n = 1'b1;
        set_ready(cyc + 1, 1'b1);
        tick();
        check("ready_after_release", req_ready, 1'b1);

        // Write line, beat k = k+1, response five cycles after the bus is released.
        run_txn(1'b1, 14'h0123, 128'h0008_0007_0006_0005_0004_0003_0002_0001, 5, 0, t, d);
        check("wr_latency", vld_cyc - t, 14);
        check("wr_err", last_err, 1'b0);
        check("wr_ready_back", req_ready, 1'b1);

        // Write with the response on the very first released cycle.
        run_txn(1'b1, 14'h2A5C, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 0, 0, t, d);
        check("wr_min_latency", vld_cyc - t, 9);

        // Read line with an immediate full burst.
        run_txn(1'b0, 14'h0040, '0, 0, BEATS, t, d);
        check("rd_latency", vld_cyc - t, 9);
        check("rd_err", last_err, 1'b0);
        check("rd_line", resp_rdata, 128'hA007_A006_A005_A004_A003_A002_A001_A000);

        // Read with no response at all.
        run_txn(1'b0, 14'h0ABC, '0, -1, 0, t, d);
        check("tmo_latency", vld_cyc - t, 257);
        check("tmo_err", last_err, 1'b1);
        check("tmo_ready_back", req_ready, 1'b1);

        // Read whose burst breaks after three beats.
        run_txn(1'b0, 14'h1234, '0, 1, 3, t, d);
        check("brk_latency", vld_cyc - t, 6);
        check("brk_err", last_err, 1'b1);
        check("brk_line", resp_rdata, 128'h0000_0000_0000_0000_0000_A002_A001_A000);

        // Reset pulled during write beat 4.
        tick();
        t         = cyc + 1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 14'h0155;
        req_wdata = 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100;
        for (int k = 0; k < 4; k++) begin
            exp_drv[t+k] = 1'b1;
            exp_c2[t+k]  = 2'd3;
            exp_a2[t+k]  = 14'h0155;
            exp_dd[t+k]  = 1'b1;
            exp_d2[t+k]  = req_wdata[k*16 +: 16];
        end
        set_ready(t, 1'b0);
        tick();
        req_valid = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check("rst_mid_c2", c2_w, 2'd0);
        check("rst_mid_d2", d2_w, 16'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        set_ready(cyc + 1, 1'b1);
        tick();
        check("rst_mid_ready", req_ready, 1'b1);
        check("rst_mid_rdata", resp_rdata, 128'h0);
        repeat (12) tick();
        check("rst_mid_no_resp", vld_cnt, 5);

        // The block must work normally after the aborted write.
        run_txn(1'b1, 14'h3FFE, 128'hDEAD_BEEF_CAFE_F00D_1357_2468_ACE0_BDF1, 2, 0, t, d);
        check("recover_latency", vld_cyc - t, 11);
        check("resp_count", vld_cnt, 6);

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
